pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. It generalises the datapath's fixed 64-bit ripple adder/subtractor. Operand width and pipeline depth are set by parameters, and it adds per-operation mode, carry-out and signed-overflow flags. It feeds the Booth multiplier's partial-product accumulation path and sustains one operation per clock.

---
 rtl/pipelined_add_sub_if.sv | 26 ++
 rtl/pipelined_add_sub.sv | 104 ++++++++++
 tb/tb_pipelined_add_sub.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// Operand/result bus for the pipelined adder/subtractor.
// Both sides use valid/ready: a beat moves on a rising edge where valid && ready are both high.
interface pipelined_add_sub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: each stage resolves one CHUNK-bit slice,
// with a global stall (out_valid && !out_ready) freezing every stage register.
module pipelined_add_sub #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_add_sub_if.slave   bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   logic stall;

   // Stage inputs (_d) and registered stage outputs (_o); stage k>0 feeds from stage k-1.
   logic [WIDTH-1:0] a_d  [STAGES];
   logic [WIDTH-1:0] b_d  [STAGES];
   logic [WIDTH-1:0] r_d  [STAGES];
   logic             c_d  [STAGES];
   logic             sa_d [STAGES];
   logic             sb_d [STAGES];
   logic             v_d  [STAGES];

   logic [WIDTH-1:0] a_o  [STAGES];
   logic [WIDTH-1:0] b_o  [STAGES];
   logic [WIDTH-1:0] r_o  [STAGES];
   logic             c_o  [STAGES];
   logic             sa_o [STAGES];
   logic             sb_o [STAGES];
   logic             v_o  [STAGES];

   assign stall        = v_o[LAST] && !bus.out_ready;
   assign bus.in_ready = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] r_nx;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] r_q;
      logic             c_q;
      logic             sa_q;
      logic             sb_q;
      logic             v_q;

      if (k == 0) begin : g_in
         // Subtraction is a + ~b + 1: invert b here and inject sub as the first carry.
         assign a_d[0]  = bus.a;
         assign b_d[0]  = bus.b ^ {WIDTH{bus.sub}};
         assign r_d[0]  = '0;
         assign c_d[0]  = bus.sub;
         assign sa_d[0] = bus.a[WIDTH-1];
         assign sb_d[0] = bus.b[WIDTH-1] ^ bus.sub;
         assign v_d[0]  = bus.in_valid && !stall;
      end else begin : g_link
         assign a_d[k]  = a_o[k-1];
         assign b_d[k]  = b_o[k-1];
         assign r_d[k]  = r_o[k-1];
         assign c_d[k]  = c_o[k-1];
         assign sa_d[k] = sa_o[k-1];
         assign sb_d[k] = sb_o[k-1];
         assign v_d[k]  = v_o[k-1];
      end

      // Operands are shifted down one chunk per stage, so every stage works on bits [CHUNK-1:0];
      // the result slice enters at the top and the partial result shifts down alongside.
      assign part = {1'b0, a_d[k][CHUNK-1:0]} + {1'b0, b_d[k][CHUNK-1:0]} + (CHUNK+1)'(c_d[k]);
      assign r_nx = WIDTH'({part[CHUNK-1:0], r_d[k]} >> CHUNK);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            r_q  <= '0;
            c_q  <= 1'b0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            v_q  <= 1'b0;
         end else if (!stall) begin
            a_q  <= a_d[k] >> CHUNK;
            b_q  <= b_d[k] >> CHUNK;
            r_q  <= r_nx;
            c_q  <= part[CHUNK];
            sa_q <= sa_d[k];
            sb_q <= sb_d[k];
            v_q  <= v_d[k];
         end
      end

      assign a_o[k]  = a_q;
      assign b_o[k]  = b_q;
      assign r_o[k]  = r_q;
      assign c_o[k]  = c_q;
      assign sa_o[k] = sa_q;
      assign sb_o[k] = sb_q;
      assign v_o[k]  = v_q;
   end

   assign bus.out_valid = v_o[LAST];
   assign bus.sum       = r_o[LAST];
   assign bus.cout      = c_o[LAST];
   assign bus.ovf       = (sa_o[LAST] == sb_o[LAST]) && (r_o[LAST][WIDTH-1] != sa_o[LAST]);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations (64/4, 32/1, 16/8) share one stimulus
// path; the selected instance is exercised and checked against an arithmetic reference.
module tb_pipelined_add_sub;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  sel = 2'd0;
   logic        in_valid_t = 1'b0;
   logic        out_ready_t = 1'b1;
   logic [63:0] a_t = '0;
   logic [63:0] b_t = '0;
   logic        sub_t = 1'b0;

   pipelined_add_sub_if #(.WIDTH(64)) bus0 ();
   pipelined_add_sub_if #(.WIDTH(32)) bus1 ();
   pipelined_add_sub_if #(.WIDTH(16)) bus2 ();

   assign bus0.in_valid  = in_valid_t && (sel == 2'd0);
   assign bus0.a         = a_t;
   assign bus0.b         = b_t;
   assign bus0.sub       = sub_t;
   assign bus0.out_ready = (sel == 2'd0) ? out_ready_t : 1'b1;
   assign bus1.in_valid  = in_valid_t && (sel == 2'd1);
   assign bus1.a         = a_t[31:0];
   assign bus1.b         = b_t[31:0];
   assign bus1.sub       = sub_t;
   assign bus1.out_ready = (sel == 2'd1) ? out_ready_t : 1'b1;
   assign bus2.in_valid  = in_valid_t && (sel == 2'd2);
   assign bus2.a         = a_t[15:0];
   assign bus2.b         = b_t[15:0];
   assign bus2.sub       = sub_t;
   assign bus2.out_ready = (sel == 2'd2) ? out_ready_t : 1'b1;

   pipelined_add_sub #(.WIDTH(64), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   pipelined_add_sub #(.WIDTH(16), .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [63:0] o_sum;
   logic        o_cout, o_ovf, o_ov, o_ir;
   always_comb begin
      o_sum  = 64'(bus0.sum);
      o_cout = bus0.cout;
      o_ovf  = bus0.ovf;
      o_ov   = bus0.out_valid;
      o_ir   = bus0.in_ready;
      case (sel)
         2'd1: begin
            o_sum = 64'(bus1.sum); o_cout = bus1.cout; o_ovf = bus1.ovf;
            o_ov = bus1.out_valid; o_ir = bus1.in_ready;
         end
         2'd2: begin
            o_sum = 64'(bus2.sum); o_cout = bus2.cout; o_ovf = bus2.ovf;
            o_ov = bus2.out_valid; o_ir = bus2.in_ready;
         end
         default: ;
      endcase
   end

   int checks = 0;
   int errors = 0;
   int cur_w = 64;
   int cur_s = 4;
   int pops = 0;
   logic [65:0] exp_q[$];
   logic        held = 1'b0;
   logic [63:0] h_sum;
   logic        h_cout, h_ovf;
   logic        last_ov, last_ir, last_acc, last_cout, last_ovf;
   logic [63:0] last_sum;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask_of(input int w);
      return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

   // Reference: signed and unsigned integer arithmetic on wide values.
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input int w);
      logic [63:0]        m;
      logic [64:0]        ua, ub;
      logic signed [66:0] sa, sb, r, lim;
      logic               rc, rv;
      m  = mask_of(w);
      ua = {1'b0, a & m};
      ub = {1'b0, b & m};
      sa = $signed({2'b00, ua});
      sb = $signed({2'b00, ub});
      if (a[w-1]) sa = sa - (67'sd1 <<< w);
      if (b[w-1]) sb = sb - (67'sd1 <<< w);
      r   = s ? (sa - sb) : (sa + sb);
      lim = 67'sd1 <<< (w - 1);
      rv  = (r >= lim) || (r < -lim);
      rc  = s ? (ua >= ub) : (((ua + ub) >> w) != 65'd0);
      return {rv, rc, r[63:0] & m};
   endfunction

   // One clock: sample just after the negedge drive, score handshakes, advance to next negedge.
   task automatic cycle();
      logic [65:0] e;
      #1;
      last_ov = o_ov; last_ir = o_ir; last_sum = o_sum; last_cout = o_cout; last_ovf = o_ovf;
      last_acc = in_valid_t && o_ir;
      chk("in_ready_rule", {63'd0, o_ir}, {63'd0, !(o_ov && !out_ready_t)});
      if (held) begin
         chk("hold_valid", {63'd0, o_ov}, 64'd1);
         chk("hold_sum", o_sum, h_sum);
         chk("hold_flags", {62'd0, o_cout, o_ovf}, {62'd0, h_cout, h_ovf});
      end
      held = o_ov && !out_ready_t;
      h_sum = o_sum; h_cout = o_cout; h_ovf = o_ovf;
      if (last_acc) exp_q.push_back(model(a_t, b_t, sub_t, cur_w));
      if (o_ov && out_ready_t) begin
         pops++;
         if (exp_q.size() == 0) begin
            chk("spurious_out", {63'd0, o_ov}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_sum", o_sum, e[63:0]);
            chk("sb_cout", {63'd0, o_cout}, {63'd0, e[64]});
            chk("sb_ovf", {63'd0, o_ovf}, {63'd0, e[65]});
         end
      end
      @(negedge clk);
   endtask

   task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [63:0] es, input logic ec, input logic ev);
      int n;
      in_valid_t = 1'b1; a_t = a; b_t = b; sub_t = s; out_ready_t = 1'b1;
      cycle();
      chk({tag, "_accept"}, {63'd0, last_acc}, 64'd1);
      in_valid_t = 1'b0;
      n = 0;
      do begin
         n++;
         cycle();
      end while (!last_ov && n < 50);
      chk({tag, "_latency"}, 64'(n), 64'(cur_s));
      chk({tag, "_sum"}, last_sum, es);
      chk({tag, "_cout"}, {63'd0, last_cout}, {63'd0, ec});
      chk({tag, "_ovf"}, {63'd0, last_ovf}, {63'd0, ev});
   endtask

   task automatic run_plan(input logic [1:0] idx, input int w, input int s);
      logic [63:0] m, maxp, lo;
      int cyc, sent, p0;
      logic win;
      sel = idx; cur_w = w; cur_s = s;
      m = mask_of(w); maxp = m >> 1;
      lo = (w == 64) ? 64'hFFFF : ((64'd1 << (w / 2)) - 64'd1);
      in_valid_t = 1'b0; out_ready_t = 1'b1;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {63'd0, o_ov}, 64'd0);
      chk("rst_sum", o_sum, 64'd0);
      chk("rst_flags", {62'd0, o_cout, o_ovf}, 64'd0);
      chk("rst_in_ready", {63'd0, o_ir}, 64'd1);
      @(negedge clk);
      exp_q.delete(); held = 1'b0;

      single("add_5_3", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0);
      single("sub_5_3", 64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);
      single("sub_3_5", 64'd3, 64'd5, 1'b1, m - 64'd1, 1'b0, 1'b0);
      single("carry_chunk", lo, 64'd1, 1'b0, (lo + 64'd1) & m, 1'b0, 1'b0);
      single("carry_all", m, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
      single("ovf_add", maxp, 64'd1, 1'b0, maxp + 64'd1, 1'b0, 1'b1);
      single("ovf_sub", maxp + 64'd1, 64'd1, 1'b1, maxp, 1'b1, 1'b1);

      // Backpressure: 10 back-to-back random beats, consumer stalls for 3 cycles mid-stream.
      cyc = 0; sent = 0; p0 = pops;
      while ((sent < 10 || exp_q.size() != 0) && cyc < 200) begin
         win = (cyc >= s + 2) && (cyc < s + 5);
         in_valid_t  = (sent < 10);
         a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom};
         sub_t = 1'($urandom_range(0, 1));
         out_ready_t = !win;
         cycle();
         chk("bp_in_ready", {63'd0, last_ir}, {63'd0, !win});
         if (last_acc) sent++;
         cyc++;
      end
      in_valid_t = 1'b0; out_ready_t = 1'b1;
      chk("bp_sent", 64'(sent), 64'd10);
      chk("bp_results", 64'(pops - p0), 64'd10);

      // Reset with beats in flight: they must vanish.
      for (int i = 0; i < 3; i++) begin
         in_valid_t = 1'b1;
         a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom}; sub_t = 1'b0;
         cycle();
      end
      in_valid_t = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {63'd0, o_ov}, 64'd0);
      chk("arst_sum", o_sum, 64'd0);
      chk("arst_flags", {62'd0, o_cout, o_ovf}, 64'd0);
      exp_q.delete(); held = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      p0 = pops;
      repeat (s + 3) cycle();
      chk("arst_no_stale", 64'(pops - p0), 64'd0);
      single("post_rst_1_1", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      run_plan(2'd0, 64, 4);
      run_plan(2'd1, 32, 1);
      run_plan(2'd2, 16, 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end
endmodule
